hazard_ctrl: RTL and testbench
==============================

# hazard_ctrl

Pipeline hazard controller for the RV32I 5-stage core. It drives the per-stage `bubbleX` (hold) and `flushX` (clear-to-NOP) controls of every inter-stage pipeline register (F, D, E, M, W), including the immediate and operand registers feeding EX. It covers load-use interlock, EX-resolved branch/jump redirects, multi-cycle instruction and data memory waits, and EX operand forwarding. It keeps a pending-redirect register so a taken branch is never lost while fetch is busy, and it exports stall and redirect performance counters.

## Interface
Parameters:
- `CNT_W`, 32: width of the performance counters.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `rs1D`, `rs2D` in 5: source registers of the instruction in D.
- `use_rs1D`, `use_rs2D` in 1: that D source is actually read.
- `rs1E`, `rs2E` in 5: source registers of the instruction in E.
- `rdE`, `rdM`, `rdW` in 5: destination registers per stage.
- `reg_writeE`, `reg_writeM`, `reg_writeW` in 1: register-file write enables per stage.
- `mem_readE` in 1: the instruction in E is a load.
- `br_takenE` in 1: taken branch or jump resolved in E.
- `br_targetE` in 32: redirect target from E.
- `imem_ready` in 1: fetch returns a valid instruction this cycle.
- `dmem_reqM`, `dmem_readyM` in 1: data-memory request and completion for M.
- `bubbleF`, `bubbleD`, `bubbleE`, `bubbleM`, `bubbleW` out 1: hold the stage register.
- `flushD`, `flushE`, `flushM`, `flushW` out 1: clear the stage register. A flush takes effect only when that stage's bubble is low.
- `pc_redirect` out 1: load `pc_redirect_target` into the PC.
- `pc_redirect_target` out 32: redirect target.
- `fwd_aE`, `fwd_bE` out 2: operand source select. 00 = register file, 01 = M result, 10 = W result.
- `stall_cnt`, `redir_cnt` out CNT_W: performance counters.

## Operation
Internal signals:
- `dstall` = dmem_reqM & ~dmem_readyM.
- `luse` = mem_readE & reg_writeE & rdE≠0 & ((rdE==rs1D & use_rs1D) | (rdE==rs2D & use_rs2D)).

Priority, evaluated each cycle. Any output not listed for a case is 0.
1. `rst` high: flushD, flushE, flushM and flushW are 1; all bubbles are 0.
2. `dstall`: bubbleF, bubbleD, bubbleE and bubbleM are 1; flushW=1. `br_takenE` is ignored, since E is frozen and re-presents it on release. The pending redirect is held.
3. `br_takenE`: flushD=1, flushE=1.
   - If imem_ready: pc_redirect=1 with target br_targetE.
   - Otherwise: bubbleF=1, and on the clock edge set redir_pend←1 and redir_pc←br_targetE.
   - `luse` is ignored in this case.
4. `redir_pend`: flushD=1.
   - If imem_ready: pc_redirect=1 with target redir_pc, and redir_pend clears on the clock edge.
   - Otherwise: bubbleF=1.
5. `luse`: bubbleF=1, bubbleD=1, flushE=1.
6. `~imem_ready`: bubbleF=1, flushD=1.

`pc_redirect_target` equals br_targetE in case 3 and redir_pc otherwise.

Forwarding, purely combinational and independent of the priority list:
- fwd_aE=01 if reg_writeM & rdM≠0 & rdM==rs1E.
- Else fwd_aE=10 if reg_writeW & rdW≠0 & rdW==rs1E.
- Else fwd_aE=00.
- M has priority over W. fwd_bE is the same rule applied to rs2E.

Counters:
- `stall_cnt` increments on every non-reset cycle with bubbleF=1.
- `redir_cnt` increments on every cycle with pc_redirect=1.
- Both wrap modulo 2^CNT_W.

## Timing
- All control outputs are combinational from the inputs and the internal registers. There is zero-cycle latency to the pipeline registers, which sample on the same edge.
- Registered state is redir_pend, redir_pc (32), stall_cnt and redir_cnt.
- Reset values: redir_pend=0, redir_pc=0, stall_cnt=0, redir_cnt=0. Asserting reset mid-stall drops any pending redirect immediately.
- A load-use stall lasts exactly 1 cycle, because the load advances to M and the EX slot becomes a bubble.
- `br_takenE` during `dstall` produces no redirect until the first cycle with dmem_readyM=1.
- `br_takenE` with imem_ready=1 in the same cycle redirects immediately and redir_pend stays 0.
- redir_pend=1 together with `dstall`: the redirect is held and issued on the first cycle where both dstall=0 and imem_ready=1.

## Structure
- Shared header `rv32_defs.vh` holds the forwarding encodings (FWD_RF, FWD_M, FWD_W) and the x0 constant. The pipeline datapath includes the same header.
- Sub-module `fwd_unit` is instantiated twice, once per operand. Inputs: rsE, rdM, rdW, reg_writeM, reg_writeW. Output: 2-bit select.
- The top level holds the priority logic, the redirect register and the counters.

## Test plan
- Load-use: lw x5 in E (rdE=5, mem_readE=1), add in D using rs1D=5 → exactly 1 cycle with bubbleF=1, bubbleD=1, flushE=1; the next cycle all zero; stall_cnt=1.
- Forwarding: rdM=rdW=7 with both writing, rs1E=7 → fwd_aE=01. Drop reg_writeM → fwd_aE=10. rdM=0 with rs1E=0 → fwd_aE=00.
- Branch, fetch ready: br_takenE=1, target 0x100, imem_ready=1 → pc_redirect=1, target 0x100, flushD=1, flushE=1; redir_cnt=1.
- Branch, fetch busy: br_takenE=1, target 0x200, imem_ready=0 for 3 cycles → pc_redirect=0 and bubbleF=1 for those cycles. On the first imem_ready=1 → pc_redirect=1, target 0x200, redir_pend clears.
- Data wait over branch: dstall for 4 cycles with br_takenE=1 → bubbleF/D/E/M=1, flushW=1, no redirect. On the dmem_readyM cycle → redirect to br_targetE.
- Reset mid-pending: redir_pend=1, then rst pulse → redir_pend=0, counters 0, all flushes 1 during reset, and no redirect afterwards.

Source files
------------

// File: rtl/hazard_ctrl_pkg.sv
// hazard_ctrl_pkg: shared definitions for the RV32I hazard controller.
// The forwarding encodings and the x0 constant are used by the pipeline
// datapath as well, so they live here. Everything else that imports this
// package gets the same values.
package hazard_ctrl_pkg;

  localparam logic [1:0] FWD_RF = 2'b00;  // operand from the register file
  localparam logic [1:0] FWD_M  = 2'b01;  // operand from the M-stage result
  localparam logic [1:0] FWD_W  = 2'b10;  // operand from the W-stage result
  localparam logic [4:0] X0     = 5'd0;
  localparam int         NUM_OPS = 2;     // EX operands: rs1, rs2

  // The hazard case that wins this cycle, in priority order.
  typedef enum logic [2:0] {
    HZ_RESET,
    HZ_DSTALL,
    HZ_BRANCH,
    HZ_PEND,
    HZ_LUSE,
    HZ_IFETCH,
    HZ_NONE
  } hz_case_e;

  // Stage controls. Bubble order is F,D,E,M,W and flush order is D,E,M,W.
  typedef struct packed {
    logic [4:0] bubble;
    logic [3:0] flush;
  } stage_ctl_t;

endpackage

// File: rtl/hazard_ctrl_if.sv
// hazard_ctrl_if: pipeline <-> hazard controller signal bundle.
//   master: pipeline side. It drives the stage register/operand info and
//           the memory handshakes, and it receives the stage controls,
//           the redirect, the forwarding selects and the counters.
//   slave : hazard controller side.
interface hazard_ctrl_if #(parameter int CNT_W = 32);
  logic [4:0]       rs1D, rs2D;
  logic             use_rs1D, use_rs2D;
  logic [4:0]       rs1E, rs2E;
  logic [4:0]       rdE, rdM, rdW;
  logic             reg_writeE, reg_writeM, reg_writeW;
  logic             mem_readE;
  logic             br_takenE;
  logic [31:0]      br_targetE;
  logic             imem_ready;
  logic             dmem_reqM, dmem_readyM;
  logic             bubbleF, bubbleD, bubbleE, bubbleM, bubbleW;
  logic             flushD, flushE, flushM, flushW;
  logic             pc_redirect;
  logic [31:0]      pc_redirect_target;
  logic [1:0]       fwd_aE, fwd_bE;
  logic [CNT_W-1:0] stall_cnt, redir_cnt;

  modport master (
    output rs1D, rs2D, use_rs1D, use_rs2D, rs1E, rs2E, rdE, rdM, rdW,
           reg_writeE, reg_writeM, reg_writeW, mem_readE, br_takenE,
           br_targetE, imem_ready, dmem_reqM, dmem_readyM,
    input  bubbleF, bubbleD, bubbleE, bubbleM, bubbleW,
           flushD, flushE, flushM, flushW, pc_redirect, pc_redirect_target,
           fwd_aE, fwd_bE, stall_cnt, redir_cnt
  );

  modport slave (
    input  rs1D, rs2D, use_rs1D, use_rs2D, rs1E, rs2E, rdE, rdM, rdW,
           reg_writeE, reg_writeM, reg_writeW, mem_readE, br_takenE,
           br_targetE, imem_ready, dmem_reqM, dmem_readyM,
    output bubbleF, bubbleD, bubbleE, bubbleM, bubbleW,
           flushD, flushE, flushM, flushW, pc_redirect, pc_redirect_target,
           fwd_aE, fwd_bE, stall_cnt, redir_cnt
  );
endinterface

// File: rtl/hazard_ctrl_fwd_unit.sv
// fwd_unit: EX operand bypass select for one source register.
//   rsE               : source register of the instruction in E
//   rdM/rdW           : destinations in M and W
//   reg_writeM/W      : write enables in M and W
//   sel               : FWD_RF / FWD_M / FWD_W. M wins because it is younger.
module fwd_unit
  import hazard_ctrl_pkg::*;
(
  input  logic [4:0] rsE,
  input  logic [4:0] rdM,
  input  logic [4:0] rdW,
  input  logic       reg_writeM,
  input  logic       reg_writeW,
  output logic [1:0] sel
);
  always_comb begin
    sel = FWD_RF;
    if (reg_writeM && rdM != X0 && rdM == rsE)      sel = FWD_M;
    else if (reg_writeW && rdW != X0 && rdW == rsE) sel = FWD_W;
  end
endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard controller for the 5-stage RV32I core.
//   clk, rst : clock; asynchronous active-high reset
//   hif      : slave side of hazard_ctrl_if. Its inputs are the stage register
//              indices and enables, the branch result and the memory
//              handshakes. Its outputs are the bubble/flush controls, the PC
//              redirect, the EX forwarding selects and the perf counters.
// The controls are combinational so that the stage registers act on the same
// edge. A taken branch that arrives while fetch is busy is parked in
// redir_pend/redir_pc until fetch can take it.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic         clk,
  input  logic         rst,
  hazard_ctrl_if.slave hif
);
  logic             dstall, luse;
  hz_case_e         hz;
  stage_ctl_t       ctl;
  logic             redirect;
  logic             set_pend, clr_pend;
  logic             redir_pend;
  logic [31:0]      redir_pc;
  logic [CNT_W-1:0] stall_cnt, redir_cnt;

  assign dstall = hif.dmem_reqM & ~hif.dmem_readyM;
  assign luse   = hif.mem_readE & hif.reg_writeE & (hif.rdE != X0) &
                  (((hif.rdE == hif.rs1D) & hif.use_rs1D) |
                   ((hif.rdE == hif.rs2D) & hif.use_rs2D));

  always_comb begin
    if (rst)                  hz = HZ_RESET;
    else if (dstall)          hz = HZ_DSTALL;
    else if (hif.br_takenE)   hz = HZ_BRANCH;
    else if (redir_pend)      hz = HZ_PEND;
    else if (luse)            hz = HZ_LUSE;
    else if (!hif.imem_ready) hz = HZ_IFETCH;
    else                      hz = HZ_NONE;
  end

  always_comb begin
    ctl      = '0;
    redirect = 1'b0;
    set_pend = 1'b0;
    clr_pend = 1'b0;
    unique case (hz)
      HZ_RESET:  ctl.flush = 4'b1111;
      // E is frozen, so a branch in E comes back when the wait releases.
      HZ_DSTALL: begin ctl.bubble = 5'b11110; ctl.flush = 4'b0001; end
      HZ_BRANCH: begin
        ctl.flush = 4'b1100;
        if (hif.imem_ready) redirect = 1'b1;
        else begin ctl.bubble = 5'b10000; set_pend = 1'b1; end
      end
      HZ_PEND: begin
        ctl.flush = 4'b1000;
        if (hif.imem_ready) begin redirect = 1'b1; clr_pend = 1'b1; end
        else ctl.bubble = 5'b10000;
      end
      HZ_LUSE:   begin ctl.bubble = 5'b11000; ctl.flush = 4'b0100; end
      HZ_IFETCH: begin ctl.bubble = 5'b10000; ctl.flush = 4'b1000; end
      default: ;
    endcase
  end

  assign {hif.bubbleF, hif.bubbleD, hif.bubbleE, hif.bubbleM, hif.bubbleW} = ctl.bubble;
  assign {hif.flushD, hif.flushE, hif.flushM, hif.flushW} = ctl.flush;
  assign hif.pc_redirect        = redirect;
  assign hif.pc_redirect_target = (hz == HZ_BRANCH) ? hif.br_targetE : redir_pc;

  // One forwarding unit per EX operand (index 0 = rs1, 1 = rs2).
  logic [NUM_OPS-1:0][4:0] rs_e;
  logic [NUM_OPS-1:0][1:0] fwd;
  assign rs_e = {hif.rs2E, hif.rs1E};

  for (genvar i = 0; i < NUM_OPS; i++) begin : g_fwd
    fwd_unit u_fwd (
      .rsE        (rs_e[i]),
      .rdM        (hif.rdM),
      .rdW        (hif.rdW),
      .reg_writeM (hif.reg_writeM),
      .reg_writeW (hif.reg_writeW),
      .sel        (fwd[i])
    );
  end

  assign hif.fwd_aE = fwd[0];
  assign hif.fwd_bE = fwd[1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      redir_pend <= 1'b0;
      redir_pc   <= '0;
      stall_cnt  <= '0;
      redir_cnt  <= '0;
    end else begin
      if (set_pend) begin
        redir_pend <= 1'b1;
        redir_pc   <= hif.br_targetE;
      end else if (clr_pend) begin
        redir_pend <= 1'b0;
      end
      if (ctl.bubble[4]) stall_cnt <= stall_cnt + 1'b1;
      if (redirect)      redir_cnt <= redir_cnt + 1'b1;
    end
  end

  assign hif.stall_cnt = stall_cnt;
  assign hif.redir_cnt = redir_cnt;
endmodule

// File: tb/tb_hazard_ctrl.sv
// Testbench for hazard_ctrl. It runs table vectors, hand-written multi-cycle
// sequences and random cycles, and checks every cycle against a reference
// model of the priority rules.
module tb_hazard_ctrl;
  typedef struct packed {
    logic [4:0]  rs1D, rs2D;
    logic        u1, u2;
    logic [4:0]  rs1E, rs2E, rdE, rdM, rdW;
    logic        weE, weM, weW, mrE, br;
    logic [31:0] tgt;
    logic        imr, dreq, drdy;
  } in_t;

  // bub = {F,D,E,M,W}, fl = {D,E,M,W}
  typedef struct packed {
    logic [4:0]  bub;
    logic [3:0]  fl;
    logic        redir;
    logic [31:0] rtgt;
    logic [1:0]  fa, fb;
  } out_t;

  typedef struct {
    in_t  i;
    out_t o;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  hazard_ctrl_if #(.CNT_W(32)) hif ();
  hazard_ctrl #(.CNT_W(32)) dut (.clk(clk), .rst(rst), .hif(hif.slave));

  int passed = 0;
  int total  = 0;

  // reference model state
  bit          m_pend;
  logic [31:0] m_pc;
  logic [31:0] m_stall, m_redir;
  out_t        last;

  task automatic chk(string nm, logic [63:0] got, logic [63:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %h expected %h", nm, got, exp);
  endtask

  function automatic logic [1:0] fwd_ref(logic [4:0] rs, in_t i);
    if (i.weM && i.rdM != 0 && i.rdM == rs) return 2'b01;
    if (i.weW && i.rdW != 0 && i.rdW == rs) return 2'b10;
    return 2'b00;
  endfunction

  function automatic out_t ref_out(in_t i, bit r);
    out_t o;
    bit dst, lu;
    o      = '0;
    o.rtgt = m_pc;
    o.fa   = fwd_ref(i.rs1E, i);
    o.fb   = fwd_ref(i.rs2E, i);
    dst = i.dreq && !i.drdy;
    lu  = i.mrE && i.weE && i.rdE != 0 &&
          ((i.rdE == i.rs1D && i.u1) || (i.rdE == i.rs2D && i.u2));
    if (r) o.fl = 4'b1111;
    else if (dst) begin o.bub = 5'b11110; o.fl = 4'b0001; end
    else if (i.br) begin
      o.fl = 4'b1100; o.rtgt = i.tgt;
      if (i.imr) o.redir = 1'b1; else o.bub = 5'b10000;
    end else if (m_pend) begin
      o.fl = 4'b1000;
      if (i.imr) o.redir = 1'b1; else o.bub = 5'b10000;
    end else if (lu) begin o.bub = 5'b11000; o.fl = 4'b0100; end
    else if (!i.imr) begin o.bub = 5'b10000; o.fl = 4'b1000; end
    return o;
  endfunction

  task automatic drive(in_t i);
    hif.rs1D = i.rs1D; hif.rs2D = i.rs2D; hif.use_rs1D = i.u1; hif.use_rs2D = i.u2;
    hif.rs1E = i.rs1E; hif.rs2E = i.rs2E;
    hif.rdE = i.rdE; hif.rdM = i.rdM; hif.rdW = i.rdW;
    hif.reg_writeE = i.weE; hif.reg_writeM = i.weM; hif.reg_writeW = i.weW;
    hif.mem_readE = i.mrE; hif.br_takenE = i.br; hif.br_targetE = i.tgt;
    hif.imem_ready = i.imr; hif.dmem_reqM = i.dreq; hif.dmem_readyM = i.drdy;
  endtask

  function automatic out_t sample();
    out_t o;
    o.bub   = {hif.bubbleF, hif.bubbleD, hif.bubbleE, hif.bubbleM, hif.bubbleW};
    o.fl    = {hif.flushD, hif.flushE, hif.flushM, hif.flushW};
    o.redir = hif.pc_redirect;
    o.rtgt  = hif.pc_redirect_target;
    o.fa    = hif.fwd_aE;
    o.fb    = hif.fwd_bE;
    return o;
  endfunction

  // One cycle: apply, compare outputs and counters, advance the model, clock.
  task automatic run(string nm, in_t i, bit r, bit use_exp, out_t e);
    out_t exp_o;
    rst = r;
    if (r) begin m_pend = 0; m_pc = '0; m_stall = '0; m_redir = '0; end
    drive(i);
    #2;
    last  = sample();
    exp_o = use_exp ? e : ref_out(i, r);
    chk({nm, "_out"}, 64'(last), 64'(exp_o));
    chk({nm, "_cnt"}, {hif.stall_cnt, hif.redir_cnt}, {m_stall, m_redir});
    if (!r) begin
      bit dst;
      dst = i.dreq && !i.drdy;
      if (exp_o.bub[4]) m_stall++;
      if (exp_o.redir)  m_redir++;
      if (!dst && i.br && !i.imr) begin m_pend = 1; m_pc = i.tgt; end
      else if (!dst && !i.br && m_pend && i.imr) m_pend = 0;
    end
    @(posedge clk);
    #1;
  endtask

  function automatic in_t idle();
    in_t i;
    i = '0;
    i.imr = 1'b1;
    return i;
  endfunction

  vec_t tbl[$];
  task automatic push(in_t i, out_t o);
    vec_t v;
    v.i = i; v.o = o;
    tbl.push_back(v);
  endtask

  initial begin
    in_t  v;
    out_t e;
    logic [31:0] s0;

    // ---- reset state ----
    run("reset", idle(), 1'b1, 1'b0, '0);
    chk("reset_flush", {60'd0, last.fl}, 64'hF);
    run("idle0", idle(), 1'b0, 1'b0, '0);

    // ---- table vectors (no pending redirect, redir_pc = 0) ----
    v = idle(); e = '0; push(v, e);
    v = idle(); v.rdM = 7; v.rdW = 7; v.weM = 1; v.weW = 1; v.rs1E = 7;
    e = '0; e.fa = 2'b01; push(v, e);
    v.weM = 0; e.fa = 2'b10; push(v, e);
    v = idle(); v.weM = 1; v.weW = 1; e = '0; push(v, e);  // x0 never forwards
    v = idle(); v.rdM = 9; v.rdW = 9; v.weM = 1; v.weW = 1; v.rs2E = 9;
    e = '0; e.fb = 2'b01; push(v, e);
    v = idle(); v.rdE = 5; v.mrE = 1; v.weE = 1; v.rs1D = 5; v.u1 = 1;
    e = '0; e.bub = 5'b11000; e.fl = 4'b0100; push(v, e);
    v.u1 = 0; e = '0; push(v, e);
    v = idle(); v.mrE = 1; v.weE = 1; v.u1 = 1; e = '0; push(v, e);   // rdE = x0
    v = idle(); v.rdE = 3; v.mrE = 1; v.weE = 1; v.rs2D = 3; v.u2 = 1;
    e = '0; e.bub = 5'b11000; e.fl = 4'b0100; push(v, e);
    v = idle(); v.br = 1; v.tgt = 32'h100;
    e = '0; e.fl = 4'b1100; e.redir = 1; e.rtgt = 32'h100; push(v, e);
    v.rdE = 5; v.mrE = 1; v.weE = 1; v.rs1D = 5; v.u1 = 1; push(v, e);  // branch beats luse
    v = idle(); v.imr = 0; e = '0; e.bub = 5'b10000; e.fl = 4'b1000; push(v, e);
    v = idle(); v.dreq = 1; v.br = 1; v.tgt = 32'h300;
    e = '0; e.bub = 5'b11110; e.fl = 4'b0001; push(v, e);
    v = idle(); v.dreq = 1; v.drdy = 1; e = '0; push(v, e);

    foreach (tbl[k]) run($sformatf("tbl%0d", k), tbl[k].i, 1'b0, 1'b1, tbl[k].o);

    // ---- load-use lasts one cycle ----
    s0 = hif.stall_cnt;
    v = idle(); v.rdE = 5; v.mrE = 1; v.weE = 1; v.rs1D = 5; v.u1 = 1;
    run("luse_a", v, 1'b0, 1'b0, '0);
    run("luse_b", idle(), 1'b0, 1'b0, '0);
    chk("luse_after", 64'(last), 64'(0));
    chk("luse_cnt", 64'(hif.stall_cnt - s0), 64'd1);

    // ---- branch while fetch busy: held 3 cycles, then issued ----
    v = idle(); v.br = 1; v.tgt = 32'h200; v.imr = 0;
    run("bbusy0", v, 1'b0, 1'b0, '0);
    v = idle(); v.imr = 0;
    run("bbusy1", v, 1'b0, 1'b0, '0);
    chk("bbusy_hold", {last.redir, last.bub[4]}, 64'b01);
    run("bbusy2", v, 1'b0, 1'b0, '0);
    run("bbusy3", idle(), 1'b0, 1'b0, '0);
    chk("bbusy_issue", {last.redir, last.rtgt}, {1'b1, 32'h200});
    run("bbusy4", idle(), 1'b0, 1'b0, '0);
    chk("bbusy_clear", 64'(last.redir), 64'd0);

    // ---- data wait over a branch ----
    v = idle(); v.br = 1; v.tgt = 32'h440; v.dreq = 1;
    for (int c = 0; c < 4; c++) run("dwait", v, 1'b0, 1'b0, '0);
    chk("dwait_noredir", 64'(last.redir), 64'd0);
    v.drdy = 1;
    run("dwait_rel", v, 1'b0, 1'b0, '0);
    chk("dwait_issue", {last.redir, last.rtgt}, {1'b1, 32'h440});

    // ---- pending redirect held across dstall ----
    v = idle(); v.br = 1; v.tgt = 32'h550; v.imr = 0;
    run("pds0", v, 1'b0, 1'b0, '0);
    v = idle(); v.dreq = 1;
    run("pds1", v, 1'b0, 1'b0, '0);
    run("pds2", v, 1'b0, 1'b0, '0);
    run("pds3", idle(), 1'b0, 1'b0, '0);
    chk("pds_issue", {last.redir, last.rtgt}, {1'b1, 32'h550});

    // ---- reset while a redirect is pending ----
    v = idle(); v.br = 1; v.tgt = 32'h660; v.imr = 0;
    run("rpend0", v, 1'b0, 1'b0, '0);
    run("rpend_rst", idle(), 1'b1, 1'b0, '0);
    chk("rpend_rst_cnt", {hif.stall_cnt, hif.redir_cnt}, 64'd0);
    run("rpend1", idle(), 1'b0, 1'b0, '0);
    chk("rpend_noredir", 64'(last.redir), 64'd0);

    // ---- random ----
    for (int n = 0; n < 600; n++) begin
      v = '0;
      v.rs1D = 5'($urandom_range(0, 3)); v.rs2D = 5'($urandom_range(0, 3));
      v.u1 = 1'($urandom); v.u2 = 1'($urandom);
      v.rs1E = 5'($urandom_range(0, 3)); v.rs2E = 5'($urandom_range(0, 3));
      v.rdE = 5'($urandom_range(0, 3)); v.rdM = 5'($urandom_range(0, 3));
      v.rdW = 5'($urandom_range(0, 3));
      v.weE = 1'($urandom); v.weM = 1'($urandom); v.weW = 1'($urandom);
      v.mrE = 1'($urandom); v.br = ($urandom_range(0, 4) == 0);
      v.tgt = $urandom; v.imr = ($urandom_range(0, 9) < 7);
      v.dreq = ($urandom_range(0, 9) < 3); v.drdy = 1'($urandom);
      run("rnd", v, ($urandom_range(0, 99) < 2), 1'b0, '0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
